// File: rtl/square_sweep_pkg.sv
// Shared definitions for the square-wave DDS frequency sweep controller:
// FSM state encoding and default word widths.
package square_sweep_pkg;

  localparam int unsigned CW_DEF = 32;
  localparam int unsigned AW_DEF = 14;
  localparam int unsigned DW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_END   = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/sweep_period_tracker.sv
// Follows the square-DDS output period: pcnt runs 0..word inclusive and wraps,
// so one period lasts word+1 clocks; period_tick marks the last clock of it.
module sweep_period_tracker #(
  parameter int unsigned CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CW-1:0] word,
  output logic          period_tick
);

  logic [CW-1:0] pcnt_q, pcnt_d;

  // Held at zero while disabled so every sweep starts on a fresh period.
  always_comb begin
    pcnt_d = '0;
    if (en && (pcnt_q != word)) pcnt_d = pcnt_q + 1'b1;
  end

  assign period_tick = en && (pcnt_q == word);

  // NOTE: sequential state is assigned with non-blocking (<=) only, so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) pcnt_q <= '0;
    else     pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/square_sweep_ctrl.sv
// Stepped frequency sweep controller driving a square-wave DDS: the period word
// walks start..stop by step, holding each value for cfg_dwell full periods.
// Define SQUARE_SWEEP_LOOP_EN to restart the sweep endlessly instead of ending.
module square_sweep_ctrl
  import square_sweep_pkg::*;
#(
  parameter int unsigned CW = CW_DEF,
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CW-1:0]        cfg_start_word,
  input  logic [CW-1:0]        cfg_stop_word,
  input  logic [CW-1:0]        cfg_step_word,
  input  logic [DW-1:0]        cfg_dwell,
  input  logic [CW-1:0]        cfg_pha,
  input  logic signed [AW-1:0] cfg_amp,
  output logic                 dds_en,
  output logic [CW-1:0]        dds_cnt_word,
  output logic [CW-1:0]        dds_cmp_word,
  output logic [CW-1:0]        dds_pha_word,
  output logic signed [AW-1:0] dds_amp_word,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err,
  output logic                 period_tick,
  output logic [DW-1:0]        step_idx
);

  sweep_state_e          state_q, state_d;
  logic [CW-1:0]         cur_q, cur_d;
  logic [CW-1:0]         stop_q, stop_d;
  logic [CW-1:0]         step_q, step_d;
  logic [DW-1:0]         dwell_cfg_q, dwell_cfg_d;
  logic [DW-1:0]         dwell_cnt_q, dwell_cnt_d;
  logic [DW-1:0]         step_idx_q, step_idx_d;
  logic [CW-1:0]         pha_q, pha_d;
  logic signed [AW-1:0]  amp_q, amp_d;
  logic                  cfg_err_q, cfg_err_d;
`ifdef SQUARE_SWEEP_LOOP_EN
  logic [CW-1:0]         base_q, base_d;
`endif

  logic          tick;
  logic [CW:0]   next_sum;
  logic          next_ok;
  logic          dwell_last;
  logic          cfg_bad;

  sweep_period_tracker #(.CW(CW)) u_period (
    .clk         (clk),
    .rst         (rst),
    .en          (state_q == ST_DWELL),
    .word        (cur_q),
    .period_tick (tick)
  );

  // One extra bit catches wrap-around of the word so it cannot sneak under stop.
  assign next_sum   = {1'b0, cur_q} + {1'b0, step_q};
  assign next_ok    = !next_sum[CW] && (next_sum[CW-1:0] <= stop_q);
  assign dwell_last = (dwell_cfg_q == '0) || (dwell_cnt_q == dwell_cfg_q - 1'b1);
  assign cfg_bad    = (cfg_step_word == '0) || (cfg_start_word > cfg_stop_word);

  always_ff @(posedge clk) begin
    // NOTE: the latched configuration is reset along with the state so a
    // reset mid-sweep leaves nothing behind that a later start could reuse.
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      stop_q      <= '0;
      step_q      <= '0;
      dwell_cfg_q <= '0;
      dwell_cnt_q <= '0;
      step_idx_q  <= '0;
      pha_q       <= '0;
      amp_q       <= '0;
      cfg_err_q   <= 1'b0;
`ifdef SQUARE_SWEEP_LOOP_EN
      base_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      stop_q      <= stop_d;
      step_q      <= step_d;
      dwell_cfg_q <= dwell_cfg_d;
      dwell_cnt_q <= dwell_cnt_d;
      step_idx_q  <= step_idx_d;
      pha_q       <= pha_d;
      amp_q       <= amp_d;
      cfg_err_q   <= cfg_err_d;
`ifdef SQUARE_SWEEP_LOOP_EN
      base_q      <= base_d;
`endif
    end
  end

  // NOTE: every variable gets a default at the top of the block, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    stop_d      = stop_q;
    step_d      = step_q;
    dwell_cfg_d = dwell_cfg_q;
    dwell_cnt_d = dwell_cnt_q;
    step_idx_d  = step_idx_q;
    pha_d       = pha_q;
    amp_d       = amp_q;
    cfg_err_d   = 1'b0;
`ifdef SQUARE_SWEEP_LOOP_EN
    base_d      = base_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d     = ST_DWELL;
            cur_d       = cfg_start_word;
            stop_d      = cfg_stop_word;
            step_d      = cfg_step_word;
            dwell_cfg_d = cfg_dwell;
            pha_d       = cfg_pha;
            amp_d       = cfg_amp;
            dwell_cnt_d = '0;
            step_idx_d  = '0;
`ifdef SQUARE_SWEEP_LOOP_EN
            base_d      = cfg_start_word;
`endif
          end
        end
      end

      ST_DWELL: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (dwell_last) begin
            dwell_cnt_d = '0;
            if (next_ok) begin
              cur_d      = next_sum[CW-1:0];
              step_idx_d = (step_idx_q == '1) ? step_idx_q : step_idx_q + 1'b1;
            end else begin
`ifdef SQUARE_SWEEP_LOOP_EN
              cur_d      = base_q;
              step_idx_d = '0;
`else
              state_d    = ST_END;
`endif
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q + 1'b1;
          end
        end
      end

      ST_END:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // DDS drive is zeroed whenever no sweep is running.
  always_comb begin
    busy         = (state_q == ST_DWELL);
    dds_en       = busy;
    done         = (state_q == ST_END);
    cfg_err      = cfg_err_q;
    period_tick  = tick;
    step_idx     = step_idx_q;
    dds_cnt_word = busy ? cur_q        : '0;
    dds_cmp_word = busy ? (cur_q >> 1) : '0;
    dds_pha_word = busy ? pha_q        : '0;
    dds_amp_word = busy ? amp_q        : '0;
  end

endmodule
